cache_victim_writeback: RTL

- Takes the victim way chosen by the cache replacement logic and, if that line is dirty, reads it from the data array.
- Streams the line to the bus write path as BEATS beats over a valid/ready handshake, then clears the way's dirty bit.
- Sits between the cache replacement/victim selection and the bus interface; it is the consumer of VictimWay.
- Clean victims complete with no bus traffic.

---
 rtl/cache_wb_pkg.sv | 30 +++
 rtl/wb_line_buffer.sv | 36 +++
 rtl/cache_victim_writeback.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_wb_pkg.sv
// Shared types and elaboration-time helpers for the cache victim write-back
// block.
//
// Contents:
//   wbstate_t     write-back FSM state encoding
//   log2Int       ceiling log2 of a positive constant
//   beatCount     number of bus beats per cache line
//   beatAdrBits   byte-address bits spanned by one bus beat
package cache_wb_pkg;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} wbstate_t;

  function automatic int log2Int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int beatCount(input int lineLen, input int beatLen);
    return lineLen / beatLen;
  endfunction

  function automatic int beatAdrBits(input int beatLen);
    return log2Int(beatLen / 8);
  endfunction

endpackage

// File: rtl/wb_line_buffer.sv
// Holds one captured cache line and presents the beat selected by the beat
// counter.
//
// Ports:
//   clk      clock
//   reset    synchronous active-high reset, clears the buffer
//   load     capture lineIn this cycle
//   lineIn   full line from the data array
//   beatSel  beat index into the buffered line
//   beatOut  selected beat
module wb_line_buffer
  import cache_wb_pkg::*;
#(
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  localparam int BEATS  = beatCount(LINELEN, BEATLEN),
  localparam int CNTLEN = log2Int(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LINELEN-1:0] lineIn,
  input  logic [CNTLEN-1:0]  beatSel,
  output logic [BEATLEN-1:0] beatOut
);

  logic [BEATS-1:0][BEATLEN-1:0] lineQ;

  always_ff @(posedge clk) begin
    if (reset)     lineQ <= '0;
    else if (load) lineQ <= lineIn;
  end

  assign beatOut = lineQ[beatSel];

endmodule

// File: rtl/cache_victim_writeback.sv
// Writes a dirty victim line back to the bus. On Start the victim way, set
// and tag are latched; dirty victims are read from the data array, streamed
// out as BEATS beats over a valid/ready handshake, and their dirty bit is
// cleared. Clean victims complete immediately with no bus traffic.
//
// Optional feature: define CACHE_WB_PERFCNT_EN to add EvictCount and
// WritebackCount (32-bit, wrapping, cleared by reset).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Start                 eviction request, only honoured in IDLE
//   VictimWay/DirtyWay    one-hot victim and dirty bits of the set
//   TagWay, SetIdx        tags of the set, set index of the victim
//   ArrayRdEn, ArrayWay   data array read strobe and way
//   ReadData              line returned the cycle after ArrayRdEn
//   WBValid/WBReady       beat handshake; WBAdr, WBData, WBLast beat payload
//   ClearDirty            one-cycle one-hot dirty clear
//   Busy, Done            activity flag, one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for Start
// READ    | data array read strobe for the latched way
// CAPTURE | array data valid, loaded into the line buffer
// SEND    | streaming beats, counter advances on each accept
// DONE    | completion pulse, dirty clear if the line was written
module cache_victim_writeback
  import cache_wb_pkg::*;
#(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 9,
  parameter int OFFSETLEN = 6,
  parameter int TAGLEN    = 20,
  parameter int LINELEN   = 512,
  parameter int BEATLEN   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Start,
  input  logic [NUMWAYS-1:0]              VictimWay,
  input  logic [NUMWAYS-1:0]              DirtyWay,
  input  logic [NUMWAYS*TAGLEN-1:0]       TagWay,
  input  logic [SETLEN-1:0]               SetIdx,
  output logic                            ArrayRdEn,
  output logic [NUMWAYS-1:0]              ArrayWay,
  input  logic [LINELEN-1:0]              ReadData,
  output logic                            WBValid,
  input  logic                            WBReady,
  output logic [TAGLEN+SETLEN+OFFSETLEN-1:0] WBAdr,
  output logic [BEATLEN-1:0]              WBData,
  output logic                            WBLast,
  output logic [NUMWAYS-1:0]              ClearDirty,
  output logic                            Busy,
  output logic                            Done
`ifdef CACHE_WB_PERFCNT_EN
  ,
  output logic [31:0]                     EvictCount,
  output logic [31:0]                     WritebackCount
`endif
);

  localparam int BEATS     = beatCount(LINELEN, BEATLEN);
  localparam int CNTLEN    = log2Int(BEATS);
  localparam int BYTESHIFT = beatAdrBits(BEATLEN);

  wbstate_t state, nextState;

  logic [NUMWAYS-1:0]   wayQ;
  logic [SETLEN-1:0]    setQ;
  logic [TAGLEN-1:0]    tagQ;
  logic                 dirtyQ;
  logic [CNTLEN-1:0]    cnt;
  logic [TAGLEN-1:0]    victimTag;
  logic [OFFSETLEN-1:0] beatOffset;
  logic [BEATLEN-1:0]   beatData;
  logic                 loadLine;

  // OR of selected tags: exact for a one-hot VictimWay.
  always_comb begin
    victimTag = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (VictimWay[i]) victimTag = victimTag | TagWay[i*TAGLEN +: TAGLEN];
    end
  end

  // Beat index sits just above the bytes covered by one beat.
  always_comb begin
    beatOffset = '0;
    beatOffset[BYTESHIFT +: CNTLEN] = cnt;
  end

  wb_line_buffer #(
    .LINELEN (LINELEN),
    .BEATLEN (BEATLEN)
  ) u_lineBuf (
    .clk     (clk),
    .reset   (reset),
    .load    (loadLine),
    .lineIn  (ReadData),
    .beatSel (cnt),
    .beatOut (beatData)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wayQ   <= '0;
      setQ   <= '0;
      tagQ   <= '0;
      dirtyQ <= 1'b0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && Start) begin
        wayQ   <= VictimWay;
        setQ   <= SetIdx;
        tagQ   <= victimTag;
        dirtyQ <= |(VictimWay & DirtyWay);
      end
      // The counter wraps back to 0 on the last accept; the FSM leaves SEND.
      if (state == CAPTURE)             cnt <= '0;
      else if (state == SEND && WBReady) cnt <= cnt + CNTLEN'(1);
    end
  end

  always_comb begin
    nextState  = state;
    ArrayRdEn  = 1'b0;
    ArrayWay   = '0;
    WBValid    = 1'b0;
    WBAdr      = '0;
    WBData     = '0;
    WBLast     = 1'b0;
    ClearDirty = '0;
    Busy       = (state != IDLE);
    Done       = 1'b0;
    loadLine   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) nextState = (|(VictimWay & DirtyWay)) ? READ : DONE;
      end
      READ: begin
        ArrayRdEn = 1'b1;
        ArrayWay  = wayQ;
        nextState = CAPTURE;
      end
      CAPTURE: begin
        loadLine  = 1'b1;
        nextState = SEND;
      end
      SEND: begin
        WBValid = 1'b1;
        WBData  = beatData;
        WBAdr   = {tagQ, setQ, beatOffset};
        WBLast  = (cnt == CNTLEN'(BEATS - 1));
        if (WBReady && WBLast) nextState = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (dirtyQ) ClearDirty = wayQ;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef CACHE_WB_PERFCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      EvictCount     <= '0;
      WritebackCount <= '0;
    end else begin
      if (Done)                 EvictCount     <= EvictCount + 32'd1;
      if (Done && |ClearDirty)  WritebackCount <= WritebackCount + 32'd1;
    end
  end
`endif

endmodule
